// File: rtl/centroid_pkg.sv
// centroid_pkg: shared sizes and FSM state for the centroid moment path.
// Widths: lanes 14b, line sum 17b, accumulator 22b.
package centroid_pkg;

  localparam int LANES  = 18;
  localparam int BW_IN  = 14;
  localparam int BW_ROW = 17;
  localparam int ROWS   = 37;
  localparam int BW_ACC = 22;

  localparam int GRP     = 6;
  localparam int NGRP    = LANES / GRP;
  localparam int BW_PART = BW_IN + 3;
  localparam int BW_CNT  = $clog2(ROWS + 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/Delay_reg.sv
// Delay_reg: single-stage enable register with synchronous active-low clear.
// Shared by the adder tree for partial sums and line flags.
module Delay_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clear on reset, otherwise advance only when enabled
  always_ff @(posedge clk) begin
    if (!rst)
      q <= '0;
    else if (ena)
      q <= d;
  end

endmodule

// File: rtl/centroid_row_adder.sv
// centroid_row_adder: two-stage 18-to-1 signed adder tree.
// S1 forms three 6-lane partials, S2 the line sum; flags ride along.
module centroid_row_adder
  import centroid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic [LANES*BW_IN-1:0]   in_bus,
  output logic signed [BW_ROW-1:0] row,
  output logic                     row_valid,
  output logic                     row_sop
);

  logic [NGRP*BW_PART-1:0] part_d;
  logic [NGRP*BW_PART-1:0] part_q;
  logic signed [BW_PART-1:0] psum;
  logic signed [BW_ROW-1:0]  row_d;
  logic [1:0]                f1_q;
  logic [BW_ROW+1:0]         s2_q;

  // S1: sign-extended 6-lane partial sums
  always_comb begin
    part_d = '0;
    psum   = '0;
    for (int g = 0; g < NGRP; g++) begin
      psum = '0;
      for (int l = 0; l < GRP; l++)
        psum = psum + BW_PART'($signed(
          in_bus[(g*GRP+l)*BW_IN +: BW_IN]));
      part_d[g*BW_PART +: BW_PART] = psum;
    end
  end

  Delay_reg #(.W(NGRP*BW_PART)) u_s1_part (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .d   (part_d),
    .q   (part_q)
  );

  Delay_reg #(.W(2)) u_s1_flag (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .d   ({in_valid, in_valid & in_sop}),
    .q   (f1_q)
  );

  // S2: fold the three partials into one line sum
  always_comb begin
    row_d = '0;
    for (int g = 0; g < NGRP; g++)
      row_d = row_d + BW_ROW'($signed(
        part_q[g*BW_PART +: BW_PART]));
  end

  Delay_reg #(.W(BW_ROW+2)) u_s2 (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .d   ({row_d, f1_q}),
    .q   (s2_q)
  );

  assign row       = $signed(s2_q[BW_ROW+1:2]);
  assign row_valid = s2_q[1];
  assign row_sop   = s2_q[0];

endmodule

// File: rtl/centroid_moment_accumulator.sv
// centroid_moment_accumulator: sums 37 line sums into one patch moment.
// CENTROID_ACC_SAT_EN: saturating accumulator plus a sat pulse output.
module centroid_moment_accumulator
  import centroid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic [LANES*BW_IN-1:0]   in_bus,
  output logic signed [BW_ACC-1:0] moment,
  output logic                     out_valid,
  output logic                     abort
`ifdef CENTROID_ACC_SAT_EN
  ,
  output logic                     sat
`endif
);

  localparam int BW_EXT =
    (BW_ACC > BW_ROW ? BW_ACC : BW_ROW) + 1;

  logic signed [BW_ROW-1:0] row;
  logic                     row_valid;
  logic                     row_sop;

  state_t                   state, state_n;
  logic [BW_CNT-1:0]        cnt, cnt_n;
  logic signed [BW_ACC-1:0] acc, acc_n;
  logic signed [BW_ACC-1:0] moment_n;
  logic                     ov_n, ab_n;

  logic signed [BW_EXT-1:0] row_ext;
  logic signed [BW_EXT-1:0] sum_ext;
  logic signed [BW_ACC-1:0] ld_val;
  logic signed [BW_ACC-1:0] add_val;

  centroid_row_adder u_tree (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_bus    (in_bus),
    .row       (row),
    .row_valid (row_valid),
    .row_sop   (row_sop)
  );

  assign row_ext = BW_EXT'(row);
  assign sum_ext = BW_EXT'(acc) + row_ext;

`ifdef CENTROID_ACC_SAT_EN
  localparam logic signed [BW_EXT-1:0] MAX_V =
    BW_EXT'((2 ** (BW_ACC - 1)) - 1);
  localparam logic signed [BW_EXT-1:0] MIN_V =
    BW_EXT'(-(2 ** (BW_ACC - 1)));

  logic satf, satf_n, sat_n;
  logic ld_ovf, add_ovf;

  function automatic logic signed [BW_ACC-1:0] fit(
    input logic signed [BW_EXT-1:0] x
  );
    if (x > MAX_V)
      return BW_ACC'(MAX_V);
    else if (x < MIN_V)
      return BW_ACC'(MIN_V);
    else
      return BW_ACC'(x);
  endfunction

  assign ld_ovf  = (row_ext > MAX_V) || (row_ext < MIN_V);
  assign add_ovf = (sum_ext > MAX_V) || (sum_ext < MIN_V);
  assign ld_val  = fit(row_ext);
  assign add_val = fit(sum_ext);
`else
  assign ld_val  = BW_ACC'(row_ext);
  assign add_val = BW_ACC'(sum_ext);
`endif

  // S3: patch FSM, next accumulator, count and output pulses
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    moment_n = moment;
    ov_n     = 1'b0;
    ab_n     = 1'b0;
`ifdef CENTROID_ACC_SAT_EN
    satf_n   = satf;
    sat_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (row_valid && row_sop) begin
          acc_n   = ld_val;
          cnt_n   = BW_CNT'(1);
          state_n = ACCUM;
`ifdef CENTROID_ACC_SAT_EN
          satf_n  = ld_ovf;
`endif
        end
      end
      ACCUM: begin
        if (row_valid && row_sop) begin
          acc_n  = ld_val;
          cnt_n  = BW_CNT'(1);
          ab_n   = 1'b1;
`ifdef CENTROID_ACC_SAT_EN
          satf_n = ld_ovf;
`endif
        end else if (row_valid) begin
          acc_n = add_val;
`ifdef CENTROID_ACC_SAT_EN
          satf_n = satf | add_ovf;
`endif
          if (cnt == BW_CNT'(ROWS - 1)) begin
            moment_n = add_val;
            ov_n     = 1'b1;
            cnt_n    = '0;
            state_n  = IDLE;
`ifdef CENTROID_ACC_SAT_EN
            sat_n    = satf | add_ovf;
`endif
          end else begin
            cnt_n = cnt + BW_CNT'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // S3 registers; ena low freezes everything including pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      moment    <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
`ifdef CENTROID_ACC_SAT_EN
      satf      <= 1'b0;
      sat       <= 1'b0;
`endif
    end else if (ena) begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      moment    <= moment_n;
      out_valid <= ov_n;
      abort     <= ab_n;
`ifdef CENTROID_ACC_SAT_EN
      satf      <= satf_n;
      sat       <= sat_n;
`endif
    end
  end

endmodule

// File: tb/tb_centroid_moment_accumulator.sv
// tb_centroid_moment_accumulator: directed patches plus random traffic
// compared cycle by cycle against a behavioural patch model.
module tb_centroid_moment_accumulator;
  import centroid_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ena;
  logic                     in_valid;
  logic                     in_sop;
  logic [LANES*BW_IN-1:0]   in_bus;
  logic signed [BW_ACC-1:0] moment;
  logic                     out_valid;
  logic                     abort;
`ifdef CENTROID_ACC_SAT_EN
  logic                     sat;
`endif

  centroid_moment_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_bus    (in_bus),
    .moment    (moment),
    .out_valid (out_valid),
    .abort     (abort)
`ifdef CENTROID_ACC_SAT_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     v;
    bit     s;
    longint r;
  } line_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     lane[LANES];
  line_t  pipe[$];
  bit     act;
  int     mcnt;
  longint msum;
  longint e_mom;
  bit     e_ov;
  bit     e_ab;
  int     cyc = 0;
  int     ov_cyc[$];
  longint ov_mom[$];
  int     n_ab;

  task automatic check(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(longint x);
    longint m;
    m = x & ((64'sd1 << BW_ACC) - 1);
    if (m >= (64'sd1 << (BW_ACC - 1)))
      m = m - (64'sd1 << BW_ACC);
    return m;
  endfunction

  task automatic model_reset();
    line_t z;
    z.v = 0;
    z.s = 0;
    z.r = 0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    act   = 0;
    mcnt  = 0;
    msum  = 0;
    e_mom = 0;
    e_ov  = 0;
    e_ab  = 0;
  endtask

  task automatic model_line(line_t ln);
    e_ov = 0;
    e_ab = 0;
    if (ln.v) begin
      if (ln.s) begin
        if (act) e_ab = 1;
        act  = 1;
        mcnt = 1;
        msum = ln.r;
      end else if (act) begin
        msum = msum + ln.r;
        mcnt = mcnt + 1;
        if (mcnt == ROWS) begin
          e_ov  = 1;
          e_mom = wrap(msum);
          act   = 0;
        end
      end
    end
  endtask

  task automatic step(bit r, bit en, bit v, bit s);
    line_t  ln;
    line_t  nw;
    longint rs;
    rs = 0;
    rst      = r;
    ena      = en;
    in_valid = v;
    in_sop   = s;
    for (int k = 0; k < LANES; k++) begin
      in_bus[k*BW_IN +: BW_IN] = BW_IN'(lane[k]);
      rs = rs + lane[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      model_reset();
    end else if (en) begin
      ln = pipe.pop_front();
      nw.v = v;
      nw.s = s;
      nw.r = rs;
      pipe.push_back(nw);
      model_line(ln);
    end
    check("out_valid", out_valid, e_ov);
    check("abort", abort, e_ab);
    check("moment", moment, e_mom);
    if (r && en && out_valid === 1'b1) begin
      ov_cyc.push_back(cyc);
      ov_mom.push_back(moment);
    end
    if (r && en && abort === 1'b1) n_ab++;
  endtask

  task automatic fill_const(int v);
    for (int k = 0; k < LANES; k++) lane[k] = v;
  endtask

  task automatic fill_ramp(int sg);
    for (int k = 0; k < LANES; k++) lane[k] = sg * 255 * (k + 1);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < LANES; k++)
      lane[k] = int'($urandom_range(4844)) - 2422;
  endtask

  task automatic run_patch(int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, i == 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0);
  endtask

  task automatic clear_log();
    ov_cyc.delete();
    ov_mom.delete();
    n_ab = 0;
  endtask

  function automatic longint mom_at(int i);
    return (ov_mom.size() > i) ? ov_mom[i] : -1;
  endfunction

  function automatic int cyc_at(int i);
    return (ov_cyc.size() > i) ? ov_cyc[i] : -1000;
  endfunction

  initial begin
    int t0;
    int tl;
    int sent;
    int gaps;
    int bound;
    fill_const(0);
    model_reset();
    clear_log();
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    check("rst_moment", moment, 0);
    check("rst_ov", out_valid, 0);
    check("rst_abort", abort, 0);
    idle(2);

    clear_log();
    fill_const(1);
    for (int i = 0; i < ROWS; i++) begin
      tl = cyc;
      step(1, 1, 1, i == 0);
    end
    idle(6);
    check("ones_cnt", ov_cyc.size(), 1);
    check("ones_mom", mom_at(0), 666);
    check("ones_lat", cyc_at(0) - tl, 3);

    clear_log();
    fill_ramp(1);
    run_patch(ROWS);
    idle(4);
    check("ramp_pos", mom_at(0), 1613385);
    fill_ramp(-1);
    run_patch(ROWS);
    idle(4);
    check("ramp_neg", mom_at(1), -1613385);

    clear_log();
    fill_const(1);
    run_patch(ROWS);
    fill_const(2);
    run_patch(ROWS);
    idle(5);
    check("b2b_cnt", ov_cyc.size(), 2);
    check("b2b_a", mom_at(0), 666);
    check("b2b_b", mom_at(1), 1332);
    check("b2b_gap", cyc_at(1) - cyc_at(0), 37);
    check("b2b_abort", n_ab, 0);

    clear_log();
    fill_const(5);
    run_patch(10);
    fill_const(1);
    run_patch(ROWS);
    idle(5);
    check("rs_abort", n_ab, 1);
    check("rs_cnt", ov_cyc.size(), 1);
    check("rs_mom", mom_at(0), 666);

    clear_log();
    fill_const(1);
    t0 = cyc;
    sent = 0;
    gaps = 0;
    while (sent < ROWS) begin
      if (sent == 15) begin
        for (int i = 0; i < 5; i++)
          step(1, 0, ($urandom_range(1) == 1), 0);
      end
      if (sent > 0 && $urandom_range(3) == 0) begin
        step(1, 1, 0, 0);
        gaps++;
      end else begin
        step(1, 1, 1, sent == 0);
        sent++;
      end
    end
    bound = 0;
    while (ov_cyc.size() == 0 && bound < 20) begin
      step(1, 1, 0, 0);
      bound++;
    end
    check("stall_cnt", ov_cyc.size(), 1);
    check("stall_lat", cyc_at(0) - t0, 36 + gaps + 5 + 3);
    check("stall_mom", mom_at(0), 666);

    clear_log();
    fill_const(1);
    run_patch(20);
    step(0, 1, 0, 0);
    run_patch(ROWS);
    idle(5);
    check("rst_cnt", ov_cyc.size(), 1);
    check("rst_mom", mom_at(0), 666);
    check("rst_abort_n", n_ab, 0);

    clear_log();
    for (int i = 0; i < 4000; i++) begin
      fill_rand();
      step(($urandom_range(499) != 0),
           ($urandom_range(9) != 0),
           ($urandom_range(7) != 0),
           ($urandom_range(69) == 0));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
